// File: rtl/fir_mul_pipe.sv
// Pipelined signed x signed multiplier with optional rounding, arithmetic
// right shift, output saturation, sticky overflow flag and valid/ready flow
// control. Latency is NUM_STAGE clocks; the whole pipe stalls as one unit.
module fir_mul_pipe #(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 6,
  parameter int unsigned DOUT_WIDTH = 22,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND      = 0,
  parameter int unsigned NUM_STAGE  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int unsigned W       = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [W:0]  RND     = (ROUND != 0 && SHIFT > 0) ?
                                    ((W+1)'(1) << RND_POS) : '0;

  logic                adv;
  logic signed [W-1:0] prod_c;
  logic signed [W-1:0] fin_p;
  logic                fin_v;
  logic signed [W:0]   rnd_c;
  logic signed [W:0]   shf_c;
  logic [W-DOUT_WIDTH+1:0] hi_c;
  logic                sat_c;
  logic [DOUT_WIDTH-1:0] res_c;

  // Whole pipe advances when the output slot is empty or being drained
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Exact full-width signed product
  assign prod_c = W'($signed(din0)) * W'($signed(din1));

  if (NUM_STAGE == 1) begin : g_direct
    // Single stage: product feeds the round/saturate logic directly
    assign fin_p = prod_c;
    assign fin_v = in_valid;
  end else begin : g_pipe
    logic signed [W-1:0] p [NUM_STAGE-1];
    logic [NUM_STAGE-2:0] v;

    // Product register followed by pure delay stages
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v <= '0;
        for (int i = 0; i < int'(NUM_STAGE) - 1; i++) p[i] <= '0;
      end else if (adv) begin
        v[0] <= in_valid;
        if (in_valid) p[0] <= prod_c;
        for (int i = 1; i < int'(NUM_STAGE) - 1; i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) p[i] <= p[i-1];
        end
      end
    end

    assign fin_p = p[NUM_STAGE-2];
    assign fin_v = v[NUM_STAGE-2];
  end

  // Round half up, arithmetic shift, then clamp to the output range
  always_comb begin
    rnd_c = $signed({fin_p[W-1], fin_p} + RND);
    shf_c = rnd_c >>> SHIFT;
    hi_c  = shf_c[W:DOUT_WIDTH-1];
    sat_c = !((&hi_c) || !(|hi_c));
    res_c = shf_c[DOUT_WIDTH-1:0];
    if (sat_c) begin
      res_c = shf_c[W] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                       : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end

  // Output register and sticky overflow; a new saturation beats a clear
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= fin_v;
        if (fin_v) dout <= res_c;
      end
      if (adv && fin_v && sat_c) ovf <= 1'b1;
      else if (clr_ovf)          ovf <= 1'b0;
    end
  end

endmodule

// File: doc/fir_mul_pipe.md
Name: fir_mul_pipe

Overview:
- Pipelined signed×signed multiplier for the FIR datapath: multiplies a sample by a coefficient, optionally rounds and right-shifts, and saturates to the output width.
- Adds valid/ready flow control, programmable latency and an overflow flag. Sits between the tap/coefficient fetch logic and the accumulator chain.
- Throughput of one product per clock when not back-pressured.

Parameters:
- DIN0_WIDTH, 16, sample operand width (signed two's complement)
- DIN1_WIDTH, 6, coefficient operand width (signed two's complement)
- DOUT_WIDTH, 22, result width (signed); legal range 2..DIN0_WIDTH+DIN1_WIDTH
- SHIFT, 0, arithmetic right shift applied to the full product; legal range 0..DIN0_WIDTH+DIN1_WIDTH-1
- ROUND, 0, 0 = truncate (floor), 1 = round half up (add 2^(SHIFT-1) before shift); ignored when SHIFT=0
- NUM_STAGE, 2, pipeline latency in clocks; legal range 1..4

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- din0  in  DIN0_WIDTH  sample operand, signed
- din1  in  DIN1_WIDTH  coefficient operand, signed
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout
- dout  out  DOUT_WIDTH  rounded/saturated product, signed
- ovf  out  1  sticky saturation flag
- clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Reset (ap_rst_n=0, async): all stage valid bits 0, out_valid=0, dout=0, ovf=0, all stage data registers 0. In-flight products are discarded. Release is synchronous to ap_clk; first accept is possible on the first edge after release.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational, no dependency on in_valid).
- Accept: in_valid && in_ready on an edge.
- When adv=1, every stage shifts forward one position, including valid bits; bubbles propagate as valid=0.
- When adv=0, all stages hold their data and valid bits; dout and out_valid remain stable.
- Latency: NUM_STAGE edges from accept to out_valid=1 with no stall. Each stall cycle adds exactly one cycle.
- Arithmetic:
  - Stage 1 registers the full product P = din0*din1, width W = DIN0_WIDTH+DIN1_WIDTH. P is exact, including (-2^(DIN0_WIDTH-1))*(-2^(DIN1_WIDTH-1)).
  - Rounding: R = P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at W+1 bits. Then S = R >>> SHIFT (arithmetic).
  - Saturation: if S > 2^(DOUT_WIDTH-1)-1, dout = max positive; if S < -2^(DOUT_WIDTH-1), dout = min negative; otherwise dout = S. Saturation is evaluated in the final stage.
  - For NUM_STAGE=1, multiply, round and saturate all occur in the single registered stage.
  - Intermediate stages are pure delay registers that retiming may rebalance.
- ovf:
  - Set on the edge where a saturated result is loaded into the output register.
  - Cleared on an edge with clr_ovf=1 and no new saturation. Set wins over clear on the same edge.
  - A saturated result held during a stall does not re-trigger the flag.
- No combinational path from din0/din1 to dout.
- The only combinational path from out_ready is to in_ready.
- No data loss or duplication under arbitrary out_ready patterns.

Test Plan:
- Defaults. Accept din0=-32768, din1=-32 -> exactly 2 cycles later out_valid=1, dout=1048576, ovf=0.
- Streaming: 100 random operand pairs, in_valid=1 and out_ready=1 throughout -> one result per cycle, in order, bit-exact to the model; in_ready never deasserts.
- Backpressure: random out_ready (50%) with random in_valid -> output sequence identical to the unstalled run; dout stable while out_valid && !out_ready.
- Rounding, DOUT_WIDTH=22, SHIFT=1:
  - ROUND=1: 7*1 -> 4 and (-7)*1 -> -3.
  - ROUND=0: 7*1 -> 3 and (-7)*1 -> -4.
- Saturation, DOUT_WIDTH=16, SHIFT=4:
  - (-32768)*(-32) -> dout=32767, ovf=1.
  - Then 100*(-31) -> dout=-194 (ROUND=0), ovf stays 1.
  - clr_ovf pulsed on the same edge as a new saturated load -> ovf stays 1; pulsed alone -> ovf=0.
- Reset mid-operation: assert ap_rst_n=0 asynchronously with 2 products in flight -> out_valid=0, dout=0, ovf=0 immediately. After release, no stale result appears; the next accepted product emerges after NUM_STAGE cycles.
